// File: rtl/ann_weight_pkg.sv
// Shared constants and FSM encoding for the per-neuron weight fetch path.
// One package serves every Weight_x_y_z BRAM reader.
package ann_weight_pkg;

    localparam int WEIGHT_DW    = 16;
    localparam int WEIGHT_AW    = 5;
    localparam int WEIGHT_DEPTH = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// Control, BRAM read port and weight stream of one weight fetch controller.
// The controller is the master; the BRAM/consumer side is the slave.
interface weight_fetch_ctrl_if
    import ann_weight_pkg::*;
#(
    parameter int AW = WEIGHT_AW,
    parameter int DW = WEIGHT_DW
);
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do;
    logic [DW-1:0] w_data;
    logic [AW-1:0] w_index;
    logic          w_valid;
    logic          w_last;
    logic          w_ready;

    modport master (
        input  start, mem_do, w_ready,
        output busy, done, mem_en, mem_we, mem_addr, mem_di,
               w_data, w_index, w_valid, w_last
    );

    modport slave (
        output start, mem_do, w_ready,
        input  busy, done, mem_en, mem_we, mem_addr, mem_di,
               w_data, w_index, w_valid, w_last
    );
endinterface

// File: rtl/wf_skid_fifo.sv
// Two-entry FIFO holding {index, data} pairs between the BRAM and the consumer.
// Push and pop in the same cycle are both honoured; a pop on empty is ignored.
module wf_skid_fifo #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         pop_ok;
    logic [W-1:0] entry_q [2];

    assign pop_ok = pop && (count_reg != 2'd0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end

            assign entry_q[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    assign head_data = entry_q[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams words 0..DEPTH-1 of a negedge-clocked weight BRAM to the MAC datapath,
// issuing reads only when the two-entry buffer is guaranteed room for the result.
module weight_fetch_ctrl
    import ann_weight_pkg::*;
#(
    parameter int DEPTH = WEIGHT_DEPTH,
    parameter int AW    = WEIGHT_AW,
    parameter int DW    = WEIGHT_DW
) (
    input  logic                clk,
    input  logic                rst,
    weight_fetch_ctrl_if.master bus
);
    localparam int            PW       = AW + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    fetch_state_t     state_reg, state_next;
    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [AW-1:0]    addr_reg, addr_next;
    logic             inflight_reg, inflight_next;
    logic             done_reg, done_next;

    logic             issue;
    logic [PW-1:0]    issue_ptr;
    logic [1:0]       buf_count;
    logic [AW+DW-1:0] head_entry;
    logic             head_valid;
    logic             head_last;
    logic             pop;
    logic [2:0]       occ_after;
    logic             credit_ok;

    // BRAM data lands at the posedge closing the issue cycle, so the
    // in-flight read is captured unconditionally at that edge.
    wf_skid_fifo #(
        .W (AW + DW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data ({addr_reg, bus.mem_do}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (buf_count)
    );

    assign head_valid = (buf_count != 2'd0);
    assign head_last  = head_valid && (head_entry[AW+DW-1:DW] == LAST_IDX);
    assign pop        = head_valid && bus.w_ready;

    // Occupancy seen by a read issued next cycle: buffered + in flight - leaving now.
    assign occ_after = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign credit_ok = (occ_after < 3'd2);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        issue_ptr  = ptr_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = FETCH;
                    issue      = 1'b1;
                    issue_ptr  = '0;
                end
            end
            FETCH: begin
                if (inflight_reg && (addr_reg == LAST_IDX)) begin
                    state_next = DRAIN;
                end else if ((ptr_reg < DEPTH_P) && credit_ok) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        inflight_next = issue;
        addr_next     = issue ? issue_ptr[AW-1:0] : addr_reg;
        ptr_next      = issue ? (issue_ptr + PW'(1)) : ptr_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            addr_reg     <= '0;
            inflight_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            addr_reg     <= addr_next;
            inflight_reg <= inflight_next;
            done_reg     <= done_next;
        end
    end

    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.mem_en   = inflight_reg;
    assign bus.mem_we   = 1'b0;
    assign bus.mem_addr = addr_reg;
    assign bus.mem_di   = '0;
    assign bus.w_valid  = head_valid;
    assign bus.w_index  = head_entry[AW+DW-1:DW];
    assign bus.w_data   = head_entry[DW-1:0];
    assign bus.w_last   = head_last;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a negedge BRAM model holding 16'h0100+i.
module tb_weight_fetch_ctrl;
    import ann_weight_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] mem [28];

    weight_fetch_ctrl_if bus ();

    weight_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_addr < 5'd28) bus.mem_do <= mem[bus.mem_addr];
            else                      bus.mem_do <= 16'hDEAD;
        end
    end

    // One clock cycle: drive inputs just after posedge, return at negedge for sampling.
    task automatic step(input logic s, input logic r, input logic rs);
        @(posedge clk);
        #1;
        bus.start   = s;
        bus.w_ready = r;
        rst         = rs;
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.busy, bus.done, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_di,
             bus.w_data, bus.w_index, bus.w_valid, bus.w_last} !== 48'h0 || dut.state_reg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b done=%b en=%b addr=%0d wdata=%h valid=%b state=%0d, required all 0 and IDLE",
                     bus.busy, bus.done, bus.mem_en, bus.mem_addr, bus.w_data, bus.w_valid, dut.state_reg);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if ({bus.busy, bus.done, bus.mem_en, bus.w_valid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_ready c=%0d busy=%b done=%b en=%b valid=%b, required 0000",
                         c, bus.busy, bus.done, bus.mem_en, bus.w_valid);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        for (int c = 0; c <= 32; c++) begin
            logic exp_en, exp_valid, exp_busy, exp_done;
            step(c == 0, 1'b1, 1'b0);
            exp_en    = (c >= 1 && c <= 28);
            exp_valid = (c >= 2 && c <= 29);
            exp_busy  = (c >= 1 && c <= 29);
            exp_done  = (c == 30);
            n_checks++;
            if (bus.mem_we !== 1'b0 || bus.mem_di !== 16'h0 || !(bus.mem_addr <= 5'd27)) begin
                n_fail++;
                $display("FAIL t1_bram_ctrl c=%0d we=%b di=%h addr=%0d, required we=0 di=0 addr<=27",
                         c, bus.mem_we, bus.mem_di, bus.mem_addr);
            end
            n_checks++;
            if ({bus.busy, bus.done, bus.mem_en, bus.w_valid} !== {exp_busy, exp_done, exp_en, exp_valid}) begin
                n_fail++;
                $display("FAIL t1_ctrl c=%0d busy/done/en/valid=%b%b%b%b, required %b%b%b%b", c,
                         bus.busy, bus.done, bus.mem_en, bus.w_valid, exp_busy, exp_done, exp_en, exp_valid);
            end
            if (exp_en) begin
                n_checks++;
                if (bus.mem_addr !== 5'(c - 1)) begin
                    n_fail++;
                    $display("FAIL t1_addr c=%0d addr=%0d, required %0d", c, bus.mem_addr, c - 1);
                end
            end
            if (exp_valid) begin
                n_checks++;
                if (bus.w_data !== 16'h0100 + 16'(c - 2) || bus.w_index !== 5'(c - 2) || bus.w_last !== (c == 29)) begin
                    n_fail++;
                    $display("FAIL t1_word c=%0d data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b", c,
                             bus.w_data, bus.w_index, bus.w_last, 16'h0100 + 16'(c - 2), c - 2, (c == 29));
                end
            end
        end
        $display("test_stream done");
    endtask

    // mode 0: W_READY low in cycles 3..8; mode 1: W_READY toggles; mode 2: START re-pulsed at cycle 10
    task automatic test_flow(input int mode, input string tag);
        int issued = 0;
        int accepted = 0;
        int dones = 0;
        int last_xfer = -10;
        for (int c = 0; c < 75; c++) begin
            logic s, r;
            s = (c == 0) || (mode == 2 && c == 10);
            r = (mode == 0) ? !(c >= 3 && c <= 8) : (mode == 1) ? (c % 2 == 0) : 1'b1;
            step(s, r, 1'b0);
            n_checks++;
            if (bus.mem_we !== 1'b0 || bus.mem_di !== 16'h0 || !(bus.mem_addr <= 5'd27)) begin
                n_fail++;
                $display("FAIL %s_bram_ctrl c=%0d we=%b di=%h addr=%0d, required we=0 di=0 addr<=27",
                         tag, c, bus.mem_we, bus.mem_di, bus.mem_addr);
            end
            if (mode == 0 && c >= 3 && c <= 8) begin
                n_checks++;
                if (bus.w_valid !== 1'b1 || bus.w_index !== 5'd1 || bus.w_data !== 16'h0101 || bus.w_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_hold c=%0d valid=%b idx=%0d data=%h last=%b, required 1/1/0101/0",
                             tag, c, bus.w_valid, bus.w_index, bus.w_data, bus.w_last);
                end
            end
            if (bus.mem_en === 1'b1) begin
                n_checks++;
                if (issued - accepted >= 2 || bus.mem_addr !== 5'(issued)) begin
                    n_fail++;
                    $display("FAIL %s_issue c=%0d addr=%0d held=%0d, required addr=%0d held<2",
                             tag, c, bus.mem_addr, issued - accepted, issued);
                end
                issued++;
            end
            if (bus.w_valid === 1'b1 && bus.w_ready === 1'b1) begin
                n_checks++;
                if (bus.w_index !== 5'(accepted) || bus.w_data !== 16'h0100 + 16'(accepted) ||
                    bus.w_last !== (accepted == 27)) begin
                    n_fail++;
                    $display("FAIL %s_word c=%0d idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b", tag, c,
                             bus.w_index, bus.w_data, bus.w_last, accepted, 16'h0100 + 16'(accepted), (accepted == 27));
                end
                accepted++;
                last_xfer = c;
            end
            if (bus.done === 1'b1) begin
                dones++;
                n_checks++;
                if (c != last_xfer + 1 || accepted != 28 || (mode == 2 && c != 30)) begin
                    n_fail++;
                    $display("FAIL %s_done c=%0d last_xfer=%0d words=%0d, required cycle=%0d words=28",
                             tag, c, last_xfer, accepted, last_xfer + 1);
                end
            end
        end
        n_checks++;
        if (issued != 28 || accepted != 28 || dones != 1) begin
            n_fail++;
            $display("FAIL %s_totals issued=%0d words=%0d dones=%0d, required 28/28/1", tag, issued, accepted, dones);
        end
        $display("test_flow %s done: words=%0d dones=%0d", tag, accepted, dones);
    endtask

    task automatic test_rst_mid_fetch();
        int accepted = 0;
        int dones = 0;
        for (int c = 0; c <= 13; c++) begin
            step(c == 0, 1'b1, c == 12);
            if (c == 12) begin
                n_checks++;
                if (bus.busy !== 1'b1 || bus.w_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL t5_prerst busy=%b valid=%b, required 1/1", bus.busy, bus.w_valid);
                end
            end
        end
        n_checks++;
        if ({bus.busy, bus.done, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_di,
             bus.w_data, bus.w_index, bus.w_valid, bus.w_last} !== 48'h0 || dut.state_reg !== IDLE) begin
            n_fail++;
            $display("FAIL t5_after_rst busy=%b done=%b en=%b addr=%0d wdata=%h idx=%0d valid=%b state=%0d, required all 0 and IDLE",
                     bus.busy, bus.done, bus.mem_en, bus.mem_addr, bus.w_data, bus.w_index, bus.w_valid, dut.state_reg);
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if ({bus.busy, bus.done, bus.mem_en, bus.w_valid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL t5_quiet c=%0d busy=%b done=%b en=%b valid=%b, required 0000",
                         c, bus.busy, bus.done, bus.mem_en, bus.w_valid);
            end
        end
        for (int c = 0; c <= 32; c++) begin
            step(c == 0, 1'b1, 1'b0);
            if (c == 1) begin
                n_checks++;
                if (bus.mem_en !== 1'b1 || bus.mem_addr !== 5'd0) begin
                    n_fail++;
                    $display("FAIL t5_first_issue en=%b addr=%0d, required 1/0", bus.mem_en, bus.mem_addr);
                end
            end
            if (bus.w_valid === 1'b1 && bus.w_ready === 1'b1) begin
                n_checks++;
                if (bus.w_index !== 5'(accepted) || bus.w_data !== 16'h0100 + 16'(accepted) || c != accepted + 2) begin
                    n_fail++;
                    $display("FAIL t5_word c=%0d idx=%0d data=%h, required c=%0d idx=%0d data=%h", c,
                             bus.w_index, bus.w_data, accepted + 2, accepted, 16'h0100 + 16'(accepted));
                end
                accepted++;
            end
            if (bus.done === 1'b1) begin
                dones++;
                n_checks++;
                if (c != 30) begin
                    n_fail++;
                    $display("FAIL t5_done_cycle c=%0d, required 30", c);
                end
            end
        end
        n_checks++;
        if (accepted != 28 || dones != 1) begin
            n_fail++;
            $display("FAIL t5_totals words=%0d dones=%0d, required 28/1", accepted, dones);
        end
        $display("test_rst_mid_fetch done: words=%0d dones=%0d", accepted, dones);
    endtask

    initial begin
        for (int i = 0; i < 28; i++) mem[i] = 16'h0100 + 16'(i);
        bus.start   = 1'b0;
        bus.w_ready = 1'b0;
        bus.mem_do  = 16'h0;
        test_reset();
        test_stream();
        test_flow(0, "t2_backpressure");
        test_flow(1, "t3_toggle");
        test_flow(2, "t4_restart");
        test_rst_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
